rect_gen: RTL and testbench

RECT_GEN -- requirements
Module: rect_gen

---
 rtl/rect_gen_if.sv | 25 ++
 rtl/rect_gen.sv | 122 ++++++++++++
 tb/tb_rect_gen.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rect_gen_if.sv
// Run control, configuration handshake and sample output of the rectangle generator.
interface rect_gen_if #(
  parameter int OUT_W = 16,
  parameter int DIV_W = 20
);
  logic             on;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div;
  logic [7:0]       cfg_duty;
  logic [7:0]       cfg_amp;
  logic             cfg_inv;
  logic [OUT_W-1:0] rect_out;
  logic             period_start;

  modport master (
    output on, cfg_valid, cfg_div, cfg_duty, cfg_amp, cfg_inv,
    input  cfg_ready, rect_out, period_start
  );

  modport slave (
    input  on, cfg_valid, cfg_div, cfg_duty, cfg_amp, cfg_inv,
    output cfg_ready, rect_out, period_start
  );
endinterface

// File: rtl/rect_gen.sv
// Rectangle waveform generator: STEPS duty steps of div clocks each, with a
// double-buffered configuration that only changes at period boundaries while running.
module rect_gen #(
  parameter int OUT_W = 16,
  parameter int DIV_W = 20,
  parameter int STEPS = 100
) (
  input logic       clk,
  input logic       rst,
  rect_gen_if.slave bus
);

  localparam int PW = OUT_W + 8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [7:0]       step_cnt_q;
  logic [DIV_W-1:0] act_div_q, pnd_div_q;
  logic [7:0]       act_duty_q, pnd_duty_q;
  logic [7:0]       act_amp_q, pnd_amp_q;
  logic             act_inv_q, pnd_inv_q;
  logic             pnd_vld_q;
  logic [OUT_W-1:0] rect_out_q;
  logic             period_start_q;

  logic [DIV_W-1:0] div_eff;
  logic             div_term, step_term, accept;
  logic [OUT_W-1:0] level_d, sample_d;

  // Amplitude percentage to full-scale level, saturating at 100 %.
  function automatic logic [OUT_W-1:0] amp_level(input logic [7:0] amp);
    logic [PW-1:0] prod;
    if (amp >= 8'd100) return {OUT_W{1'b1}};
    prod = PW'(amp) * PW'({OUT_W{1'b1}});
    return OUT_W'(prod / PW'(100));
  endfunction

  assign div_eff   = (act_div_q == '0) ? DIV_W'(1) : act_div_q;
  assign div_term  = (div_cnt_q == div_eff - DIV_W'(1));
  assign step_term = (step_cnt_q == 8'(STEPS - 1));
  assign accept    = bus.cfg_valid && !pnd_vld_q;
  assign level_d   = amp_level(act_amp_q);
  // step_cnt never reaches STEPS, so duty >= STEPS is naturally always high.
  assign sample_d  = ((step_cnt_q < act_duty_q) ^ act_inv_q) ? level_d : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      div_cnt_q      <= '0;
      step_cnt_q     <= '0;
      act_div_q      <= DIV_W'(1);
      act_duty_q     <= '0;
      act_amp_q      <= '0;
      act_inv_q      <= 1'b0;
      pnd_div_q      <= '0;
      pnd_duty_q     <= '0;
      pnd_amp_q      <= '0;
      pnd_inv_q      <= 1'b0;
      pnd_vld_q      <= 1'b0;
      rect_out_q     <= '0;
      period_start_q <= 1'b0;
    end else begin
      if (accept) begin
        pnd_div_q  <= bus.cfg_div;
        pnd_duty_q <= bus.cfg_duty;
        pnd_amp_q  <= bus.cfg_amp;
        pnd_inv_q  <= bus.cfg_inv;
        pnd_vld_q  <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          rect_out_q     <= '0;
          period_start_q <= 1'b0;
          div_cnt_q      <= '0;
          step_cnt_q     <= '0;
          if (pnd_vld_q) begin
            act_div_q  <= pnd_div_q;
            act_duty_q <= pnd_duty_q;
            act_amp_q  <= pnd_amp_q;
            act_inv_q  <= pnd_inv_q;
            pnd_vld_q  <= 1'b0;
          end
          if (bus.on) state_q <= RUN;
        end
        RUN: begin
          if (!bus.on) begin
            state_q        <= IDLE;
            rect_out_q     <= '0;
            period_start_q <= 1'b0;
            div_cnt_q      <= '0;
            step_cnt_q     <= '0;
          end else begin
            rect_out_q     <= sample_d;
            period_start_q <= (div_cnt_q == '0) && (step_cnt_q == '0);
            if (div_term) begin
              div_cnt_q  <= '0;
              step_cnt_q <= step_term ? 8'd0 : step_cnt_q + 8'd1;
              // Pending config takes over exactly at the period wrap.
              if (step_term && pnd_vld_q) begin
                act_div_q  <= pnd_div_q;
                act_duty_q <= pnd_duty_q;
                act_amp_q  <= pnd_amp_q;
                act_inv_q  <= pnd_inv_q;
                pnd_vld_q  <= 1'b0;
              end
            end else begin
              div_cnt_q <= div_cnt_q + DIV_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cfg_ready    = !pnd_vld_q;
  assign bus.rect_out     = rect_out_q;
  assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_rect_gen.sv
// Directed bench for rect_gen: hand-computed levels, duty phases and handshake timing.
module tb_rect_gen;
  localparam int OUT_W = 16;
  localparam int DIV_W = 20;
  localparam int STEPS = 100;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rect_gen_if #(.OUT_W(OUT_W), .DIV_W(DIV_W)) bus ();

  rect_gen #(.OUT_W(OUT_W), .DIV_W(DIV_W), .STEPS(STEPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic apply_cfg(input int dv, input int dt, input int am, input bit iv);
    bus.cfg_div   = DIV_W'(dv);
    bus.cfg_duty  = 8'(dt);
    bus.cfg_amp   = 8'(am);
    bus.cfg_inv   = iv;
    bus.cfg_valid = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    chk("cfg_busy", 32'(bus.cfg_ready), 0);
    @(negedge clk);
    chk("cfg_free", 32'(bus.cfg_ready), 1);
  endtask

  task automatic wait_ps(input string tag);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.period_start) break;
    end
    chk(tag, 32'(bus.period_start), 1);
  endtask

  // Entered on the first sample of a period; leaves on the first sample of the next.
  task automatic check_period(input string tag, input int lvl, input int hi, input int total,
                              input bit iv, input int offer_at, input int offer_duty);
    int exp;
    for (int i = 0; i < total; i++) begin
      exp = ((i < hi) ^ iv) ? lvl : 0;
      chk(tag, 32'(bus.rect_out), 32'(exp));
      chk({tag, "_ps"}, 32'(bus.period_start), (i == 0) ? 32'd1 : 32'd0);
      if (i == offer_at) begin
        bus.cfg_duty  = 8'(offer_duty);
        bus.cfg_valid = 1'b1;
      end
      if (i == offer_at + 1) begin
        bus.cfg_valid = 1'b0;
        chk({tag, "_rdy_drop"}, 32'(bus.cfg_ready), 0);
      end
      if (i == offer_at + 2) begin
        bus.cfg_duty  = 8'd10;
        bus.cfg_valid = 1'b1;
      end
      if (i == offer_at + 3) begin
        bus.cfg_valid = 1'b0;
        chk({tag, "_rdy_hold"}, 32'(bus.cfg_ready), 0);
      end
      @(negedge clk);
    end
    chk({tag, "_next_ps"}, 32'(bus.period_start), 1);
  endtask

  task automatic stop_gen(input string tag);
    bus.on = 1'b0;
    @(negedge clk);
    chk({tag, "_stop_out"}, 32'(bus.rect_out), 0);
    chk({tag, "_stop_ps"}, 32'(bus.period_start), 0);
  endtask

  task automatic run_case(input string tag, input int dv, input int dt, input int am,
                          input bit iv, input int lvl, input int hi);
    apply_cfg(dv, dt, am, iv);
    bus.on = 1'b1;
    wait_ps({tag, "_start"});
    check_period(tag, lvl, hi, STEPS * ((dv == 0) ? 1 : dv), iv, -10, 0);
    stop_gen(tag);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.on        = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = '0;
    bus.cfg_duty  = '0;
    bus.cfg_amp   = '0;
    bus.cfg_inv   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(bus.rect_out), 0);
    chk("rst_ps", 32'(bus.period_start), 0);
    chk("rst_rdy", 32'(bus.cfg_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_out", 32'(bus.rect_out), 0);

    // div=4 duty=30 amp=50: 120 high, 280 low at 32767.
    apply_cfg(4, 30, 50, 0);
    bus.on = 1'b1;
    wait_ps("t1_start");
    check_period("t1", 32767, 120, 400, 0, -10, 0);
    // Mid-period offer of duty=70, then an ignored offer of duty=10.
    check_period("t2", 32767, 120, 400, 0, 100, 70);
    chk("t2_rdy_after", 32'(bus.cfg_ready), 1);
    check_period("t3", 32767, 280, 400, 0, -10, 0);
    for (int i = 0; i < 5; i++) begin
      chk("t3_run", 32'(bus.rect_out), 32767);
      @(negedge clk);
    end
    stop_gen("t3");

    run_case("amp100", 1, 50, 100, 0, 65535, 50);
    run_case("amp255", 1, 50, 255, 0, 65535, 50);
    run_case("amp1", 1, 50, 1, 0, 655, 50);
    run_case("duty0", 1, 0, 50, 0, 32767, 0);
    run_case("duty150", 1, 150, 50, 0, 32767, 100);
    run_case("div0", 0, 30, 100, 0, 65535, 30);

    // Inverted output, then stop partway through a period.
    apply_cfg(1, 30, 50, 1);
    bus.on = 1'b1;
    wait_ps("inv_start");
    check_period("inv", 32767, 30, 100, 1, -10, 0);
    for (int i = 0; i < 50; i++) begin
      chk("inv_mid", 32'(bus.rect_out), (i < 30) ? 32'd0 : 32'd32767);
      @(negedge clk);
    end
    stop_gen("inv");
    @(negedge clk);
    chk("inv_idle", 32'(bus.rect_out), 0);

    // Reset mid-period with a pending config and on held high.
    apply_cfg(1, 30, 100, 0);
    bus.on = 1'b1;
    wait_ps("rst_start");
    for (int i = 0; i < 40; i++) begin
      chk("rst_mid", 32'(bus.rect_out), (i < 30) ? 32'd65535 : 32'd0);
      @(negedge clk);
    end
    bus.cfg_duty  = 8'd90;
    bus.cfg_valid = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    chk("rst_pend", 32'(bus.cfg_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_out", 32'(bus.rect_out), 0);
    chk("rst2_ps", 32'(bus.period_start), 0);
    chk("rst2_rdy", 32'(bus.cfg_ready), 1);
    rst = 1'b0;
    wait_ps("rst_resume");
    check_period("after_rst", 0, 0, 100, 0, -10, 0);
    bus.on = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
